// File: rtl/uart_receiver.sv
// 8N1 UART receiver: mid-bit sampling, frame-error detection and
// a BREAK state that waits for the line to return high.
module uart_receiver #(
   parameter int CLKS_PER_BIT = 104
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       rx,
   output logic       uart_rx_valid,
   output logic [7:0] receive_data,
   output logic       frame_error,
   output logic       rx_busy
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
   localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BREAK = 3'd4
   } state_t;

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [2:0]    idx, idx_n;
   logic [7:0]    sh, sh_n;
   logic [7:0]    data_n;
   logic          valid_n, fe_n;
   logic          rx_q1, rx_s;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rx_q1 <= 1'b1;
         rx_s  <= 1'b1;
      end else begin
         rx_q1 <= rx;
         rx_s  <= rx_q1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state         <= IDLE;
         cnt           <= '0;
         idx           <= '0;
         sh            <= '0;
         receive_data  <= '0;
         uart_rx_valid <= 1'b0;
         frame_error   <= 1'b0;
      end else begin
         state         <= state_n;
         cnt           <= cnt_n;
         idx           <= idx_n;
         sh            <= sh_n;
         receive_data  <= data_n;
         uart_rx_valid <= valid_n;
         frame_error   <= fe_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt + 1'b1;
      idx_n   = idx;
      sh_n    = sh;
      data_n  = receive_data;
      valid_n = 1'b0;
      fe_n    = 1'b0;
      case (state)
         IDLE: begin
            cnt_n = '0;
            if (!rx_s) state_n = START;
         end
         START: begin
            if (cnt == HALF) begin
               cnt_n   = '0;
               idx_n   = '0;
               state_n = rx_s ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt == FULL) begin
               cnt_n = '0;
               sh_n  = {rx_s, sh[7:1]};
               if (idx == 3'd7) state_n = STOP;
               else             idx_n   = idx + 3'd1;
            end
         end
         STOP: begin
            // Decide at mid-stop so a following start edge is not missed
            if (cnt == FULL) begin
               cnt_n = '0;
               if (rx_s) begin
                  data_n  = sh;
                  valid_n = 1'b1;
                  state_n = IDLE;
               end else begin
                  fe_n    = 1'b1;
                  state_n = BREAK;
               end
            end
         end
         BREAK: begin
            cnt_n = '0;
            if (rx_s) state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
            cnt_n   = '0;
            idx_n   = '0;
         end
      endcase
   end

   assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: stimulus pushes expected
// events, a negedge monitor pops and compares on every output pulse.
module tb_uart_receiver;

   localparam int C = 16;
   localparam int CD = 104;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       rx = 1'b1;
   logic       rx2 = 1'b1;
   logic       valid, fe, busy;
   logic [7:0] rdata;
   logic       valid2, fe2, busy2;
   logic [7:0] rdata2;

   int n_tests = 0;
   int n_fail  = 0;

   // {is_frame_error, data}
   logic [8:0] exp_q[$];

   always #5 clk = ~clk;

   uart_receiver #(.CLKS_PER_BIT(C)) dut (
      .clk(clk), .resetn(resetn), .rx(rx),
      .uart_rx_valid(valid), .receive_data(rdata),
      .frame_error(fe), .rx_busy(busy)
   );

   uart_receiver dut2 (
      .clk(clk), .resetn(resetn), .rx(rx2),
      .uart_rx_valid(valid2), .receive_data(rdata2),
      .frame_error(fe2), .rx_busy(busy2)
   );

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Called and returns at posedge+1
   task automatic frame(input int cpb, input logic [7:0] b,
                        input logic stop, input bit line2);
      logic [9:0] bits;
      bits = {stop, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         if (line2) rx2 = bits[i];
         else       rx  = bits[i];
         repeat (cpb) @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [7:0] b);
      exp_q.push_back({1'b0, b});
      frame(C, b, 1'b1, 1'b0);
   endtask

   logic prev_pulse = 1'b0;
   always @(negedge clk) begin
      if (valid || fe) begin
         logic [8:0] e;
         chk("valid_fe_exclusive", {31'd0, valid & fe}, 32'd0);
         chk("pulse_one_cycle", {31'd0, prev_pulse}, 32'd0);
         if (exp_q.size() == 0) begin
            chk("unexpected_pulse", {23'd0, fe, rdata}, 32'h1ff);
         end else begin
            e = exp_q.pop_front();
            chk("pulse_kind", {31'd0, fe}, {31'd0, e[8]});
            if (!e[8]) chk("rx_data", {24'd0, rdata}, {24'd0, e[7:0]});
         end
      end
      prev_pulse <= valid | fe;
   end

   initial begin
      int cyc;
      int bound;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_data", {24'd0, rdata}, 32'd0);
      chk("rst_valid", {31'd0, valid}, 32'd0);
      chk("rst_fe", {31'd0, fe}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      resetn = 1'b1;
      repeat (4) @(posedge clk);
      #1;

      send(8'hA5);
      repeat (C) @(posedge clk);
      #1;

      send(8'h00);
      send(8'hFF);
      send(8'h5A);
      repeat (2 * C) @(posedge clk);
      #1;

      rx = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rx = 1'b1;
      chk("glitch_busy_hi", {31'd0, busy}, 32'd1);
      repeat (12) @(posedge clk);
      #1;
      chk("glitch_busy_lo", {31'd0, busy}, 32'd0);
      repeat (2 * C) @(posedge clk);
      #1;

      exp_q.push_back(9'h100);
      frame(C, 8'h3C, 1'b0, 1'b0);
      repeat (39 * C) @(posedge clk);
      #1;
      chk("fe_data_hold", {24'd0, rdata}, 32'h5A);
      chk("break_busy", {31'd0, busy}, 32'd1);
      rx = 1'b1;
      repeat (2 * C) @(posedge clk);
      #1;
      send(8'h81);
      repeat (2 * C) @(posedge clk);
      #1;

      // Abort 0xC3 during bit 4
      rx = 1'b0;
      repeat (C) @(posedge clk);
      for (int i = 0; i < 4; i++) begin
         #1 rx = i[0] ? 1'b1 : 1'b1;
         if (i >= 2) rx = 1'b0;
         repeat (C) @(posedge clk);
      end
      #1 rx = 1'b0;
      repeat (C / 2) @(posedge clk);
      #1 resetn = 1'b0;
      #2;
      chk("midrst_data", {24'd0, rdata}, 32'd0);
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      rx = 1'b1;
      repeat (3) @(posedge clk);
      #1 resetn = 1'b1;
      repeat (2 * C) @(posedge clk);
      #1;
      chk("post_rst_data", {24'd0, rdata}, 32'd0);
      send(8'h12);
      repeat (2 * C) @(posedge clk);
      #1;

      cyc = 0;
      fork
         frame(CD, 8'h7E, 1'b1, 1'b1);
         begin
            while (cyc < 1200) begin
               @(posedge clk);
               cyc++;
               #1;
               if (valid2) break;
            end
         end
      join
      chk("dflt_timing_ok",
          {31'd0, (cyc >= 984 && cyc <= 992)}, 32'd1);
      if (cyc < 984 || cyc > 992)
         $display("FAIL dflt_latency: got %0d expected 988+/-4", cyc);
      chk("dflt_data", {24'd0, rdata2}, 32'h7E);

      bound = 0;
      while (exp_q.size() != 0 && bound < 200) begin
         @(posedge clk);
         bound++;
      end
      repeat (4) @(posedge clk);
      #1;
      chk("queue_drained", exp_q.size(), 32'd0);
      chk("final_data", {24'd0, rdata}, 32'h12);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 104, meaning clk cycles per UART bit (12 MHz / 115200 baud); legal range 4..65535.
REQ-002 The block SHALL have port clk, input, 1, the single system clock; all state SHALL change on its rising edge.
REQ-003 The block SHALL have port resetn, input, 1, the reset; reset is asynchronous and active-low.
REQ-004 The block SHALL have port rx, input, 1, the asynchronous serial line, idle high.
REQ-005 The block SHALL have port uart_rx_valid, output, 1, a one-cycle pulse marking a correctly framed byte on receive_data.
REQ-006 The block SHALL have port receive_data, output, 8, the last correctly received byte.
REQ-007 The block SHALL have port frame_error, output, 1, a one-cycle pulse when the stop bit is sampled low.
REQ-008 The block SHALL have port rx_busy, output, 1, high whenever the state is not IDLE.

Function
REQ-009 The block SHALL pass rx through a 2-flop synchronizer (rx_s) before any use; both flops SHALL reset to 1.
REQ-010 The block SHALL implement the states IDLE, START, DATA, STOP and BREAK, with a bit-timing counter of ceil(log2(CLKS_PER_BIT)) bits and a 3-bit bit index.
REQ-011 In IDLE, rx_s == 0 SHALL move the block to START with the counter cleared; otherwise it SHALL stay in IDLE.
REQ-012 In START, when the counter reaches (CLKS_PER_BIT-1)/2 (integer division), rx_s == 0 SHALL move to DATA with the counter and bit index cleared; rx_s == 1 SHALL be a glitch and return to IDLE with no output pulse.
REQ-013 In DATA, when the counter reaches CLKS_PER_BIT-1, the block SHALL shift rx_s into the shift register LSB-first and clear the counter; after bit index 7 it SHALL go to STOP, otherwise it SHALL increment the index.
REQ-014 In STOP, when the counter reaches CLKS_PER_BIT-1 and rx_s == 1, the block SHALL load receive_data from the shift register, pulse uart_rx_valid high for exactly one cycle (the next cycle), and return to IDLE.
REQ-015 In STOP, when the counter reaches CLKS_PER_BIT-1 and rx_s == 0, the block SHALL pulse frame_error for one cycle, leave receive_data unchanged, assert no uart_rx_valid, and go to BREAK.
REQ-016 In BREAK, the block SHALL stay until rx_s == 1 and then go to IDLE, so a held-low line never yields repeated frames.
REQ-017 uart_rx_valid and frame_error SHALL never be high in the same cycle; neither SHALL be high for two consecutive cycles.
REQ-018 receive_data SHALL hold its value until the next valid frame; it SHALL never change outside a uart_rx_valid cycle.
REQ-019 Each bit sample SHALL occur within 3 clk of the nominal bit centre, measured from the rx falling edge (2 sync cycles plus 1 state-transition cycle).
REQ-020 uart_rx_valid SHALL rise 9.5*CLKS_PER_BIT +/- 4 clk after the rx start-bit falling edge.
REQ-021 Back-to-back frames with a 1-bit stop and no idle gap SHALL all be received, because STOP returns to IDLE at the mid-stop-bit point.
REQ-022 Any state value outside the five defined states SHALL return to IDLE on the next clock.

Reset
REQ-023 While resetn == 0, the block SHALL be in IDLE, with counter = 0, bit index = 0, shift register = 0x00, receive_data = 0x00, uart_rx_valid = 0, frame_error = 0, rx_busy = 0, and both synchronizer flops = 1.
REQ-024 Reset asserted mid-frame SHALL abort the frame with no output pulse.
REQ-025 After reset release, the block SHALL treat a line already low as a start bit only via the IDLE path (REQ-011).

Verification
REQ-026 CLKS_PER_BIT=16, send 0xA5 (8N1) -> exactly one uart_rx_valid pulse, receive_data=0xA5, frame_error never high.
REQ-027 CLKS_PER_BIT=16, send 0x00, 0xFF, 0x5A back-to-back with no idle gap -> three uart_rx_valid pulses carrying 0x00, 0xFF, 0x5A in order.
REQ-028 rx low for 5 clk then high (CLKS_PER_BIT=16) -> no uart_rx_valid, no frame_error, rx_busy returns to 0 within 12 clk.
REQ-029 Send 0x3C with the stop bit forced low, rx held low for 40 bit times, then 0x81 -> one frame_error pulse, receive_data stays at its prior value, then one uart_rx_valid with 0x81.
REQ-030 Assert resetn low during bit 4 of 0xC3, release, then send 0x12 -> no pulse for 0xC3; receive_data=0x00 after reset; one uart_rx_valid with 0x12.
REQ-031 Default CLKS_PER_BIT=104, send 0x7E -> uart_rx_valid rises 988 +/- 4 clk after the start edge, receive_data=0x7E.
